// File: rtl/i2c_resp_pkg.sv
// Shared types and constants for the I2C temperature-sensor responder.
package i2c_resp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_WR_BYTE  = 3'd3,
    ST_WR_ACK   = 3'd4,
    ST_RD_BYTE  = 3'd5,
    ST_RD_ACK   = 3'd6,
    ST_IGNORE   = 3'd7
  } state_t;

  localparam logic [2:0] REG_TEMP_HI = 3'd0;
  localparam logic [2:0] REG_TEMP_LO = 3'd1;
  localparam logic [2:0] REG_CONFIG  = 3'd2;
  localparam logic [2:0] REG_TOS     = 3'd3;
  localparam logic [2:0] REG_THYST   = 3'd4;

  localparam int CFG_ALERT_EN_BIT = 0;

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA conditioning: 2-FF synchronizers, optional 3-sample stable filter
// (I2C_RESP_GLITCH_FILTER_EN), SCL edge and START/STOP detection.
module i2c_line_cond (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync_r;
  logic [1:0] sda_sync_r;
  logic       scl_f_s;
  logic       sda_f_s;
  logic       scl_prev_r;
  logic       sda_prev_r;

  // Idle bus is high, so synchronizers reset to 1 to avoid a false START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
    end else begin
      scl_sync_r <= {scl_sync_r[0], scl_i};
      sda_sync_r <= {sda_sync_r[0], sda_i};
    end
  end

`ifdef I2C_RESP_GLITCH_FILTER_EN
  logic [1:0] scl_hist_r;
  logic [1:0] sda_hist_r;
  logic       scl_filt_r;
  logic       sda_filt_r;

  // A level is accepted only after three consecutive equal samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist_r <= 2'b11;
      sda_hist_r <= 2'b11;
      scl_filt_r <= 1'b1;
      sda_filt_r <= 1'b1;
    end else begin
      scl_hist_r <= {scl_hist_r[0], scl_sync_r[1]};
      sda_hist_r <= {sda_hist_r[0], sda_sync_r[1]};
      if ({scl_hist_r, scl_sync_r[1]} == 3'b111) scl_filt_r <= 1'b1;
      else if ({scl_hist_r, scl_sync_r[1]} == 3'b000) scl_filt_r <= 1'b0;
      else scl_filt_r <= scl_filt_r;
      if ({sda_hist_r, sda_sync_r[1]} == 3'b111) sda_filt_r <= 1'b1;
      else if ({sda_hist_r, sda_sync_r[1]} == 3'b000) sda_filt_r <= 1'b0;
      else sda_filt_r <= sda_filt_r;
    end
  end

  assign scl_f_s = scl_filt_r;
  assign sda_f_s = sda_filt_r;
`else
  assign scl_f_s = scl_sync_r[1];
  assign sda_f_s = sda_sync_r[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_prev_r <= scl_f_s;
      sda_prev_r <= sda_f_s;
    end
  end

  assign sda       = sda_f_s;
  assign scl_rise  = scl_f_s & ~scl_prev_r;
  assign scl_fall  = ~scl_f_s & scl_prev_r;
  assign start_det = scl_f_s & scl_prev_r & sda_prev_r & ~sda_f_s;
  assign stop_det  = scl_f_s & scl_prev_r & ~sda_prev_r & sda_f_s;

endmodule

// File: rtl/i2c_temp_responder.sv
// I2C target emulating a temperature sensor: pointer + register file, hysteretic alert.
// Optional line glitch filter enabled by defining I2C_RESP_GLITCH_FILTER_EN.
module i2c_temp_responder
  import i2c_resp_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = 7'h48,
  parameter logic [7:0] TOS_RST   = 8'h50,
  parameter logic [7:0] THYST_RST = 8'h4B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic [15:0] temp_i,
  output logic        alert_o,
  output logic        busy_o,
  output logic [7:0]  cfg_o
);

  logic        sda_s, rise_s, fall_s, start_s, stop_s;
  state_t      state_r, state_next_s;
  logic [2:0]  bit_cnt_r, ptr_r;
  logic [6:0]  shift_r, tx_r;
  logic [7:0]  cfg_r, tos_r, thyst_r, rd_data_s, rx_byte_s;
  logic [15:0] temp_q_r;
  logic        ack_phase_r, rw_r, first_byte_r, load_pend_r;
  logic        sda_oe_r, busy_r, alert_r;
  logic        bit_done_s, addr_hit_s, oe_next_s, busy_next_s;

  i2c_line_cond u_line_cond (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda       (sda_s),
    .scl_rise  (rise_s),
    .scl_fall  (fall_s),
    .start_det (start_s),
    .stop_det  (stop_s)
  );

  assign rx_byte_s  = {shift_r, sda_s};
  assign bit_done_s = rise_s && (bit_cnt_r == 3'd7);
  assign addr_hit_s = (rx_byte_s[7:1] == DEV_ADDR);

  always_comb begin
    case (ptr_r)
      REG_TEMP_HI: rd_data_s = temp_q_r[15:8];
      REG_TEMP_LO: rd_data_s = temp_q_r[7:0];
      REG_CONFIG:  rd_data_s = cfg_r;
      REG_TOS:     rd_data_s = tos_r;
      REG_THYST:   rd_data_s = thyst_r;
      default:     rd_data_s = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_next_s;
  end

  // Bus conditions override everything; otherwise advance on SCL edges.
  always_comb begin
    state_next_s = state_r;
    if (stop_s) begin
      state_next_s = ST_IDLE;
    end else if (start_s) begin
      state_next_s = ST_ADDR;
    end else begin
      case (state_r)
        ST_ADDR:     if (bit_done_s) state_next_s = addr_hit_s ? ST_ADDR_ACK : ST_IGNORE;
                     else state_next_s = state_r;
        ST_ADDR_ACK: if (fall_s && ack_phase_r) state_next_s = rw_r ? ST_RD_BYTE : ST_WR_BYTE;
                     else state_next_s = state_r;
        ST_WR_BYTE:  if (bit_done_s) state_next_s = ST_WR_ACK;
                     else state_next_s = state_r;
        ST_WR_ACK:   if (fall_s && ack_phase_r) state_next_s = ST_WR_BYTE;
                     else state_next_s = state_r;
        ST_RD_BYTE:  if (bit_done_s) state_next_s = ST_RD_ACK;
                     else state_next_s = state_r;
        ST_RD_ACK:   if (rise_s && ack_phase_r) state_next_s = sda_s ? ST_IGNORE : ST_RD_BYTE;
                     else state_next_s = state_r;
        ST_IDLE, ST_IGNORE: state_next_s = state_r;
        default:     state_next_s = ST_IDLE;
      endcase
    end
  end

  // SDA only moves right after a detected SCL fall (or on START/STOP release).
  always_comb begin
    oe_next_s = sda_oe_r;
    if (start_s || stop_s) begin
      oe_next_s = 1'b0;
    end else if (fall_s) begin
      case (state_r)
        ST_ADDR_ACK: oe_next_s = !ack_phase_r ? 1'b1 : (rw_r ? ~rd_data_s[7] : 1'b0);
        ST_WR_ACK:   oe_next_s = !ack_phase_r;
        ST_RD_BYTE:  oe_next_s = load_pend_r ? ~rd_data_s[7] : ~tx_r[6];
        default:     oe_next_s = 1'b0;
      endcase
    end else begin
      oe_next_s = sda_oe_r;
    end
    if (stop_s) busy_next_s = 1'b0;
    else if (state_r == ST_ADDR && bit_done_s && addr_hit_s) busy_next_s = 1'b1;
    else busy_next_s = busy_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_oe_r     <= 1'b0;
      busy_r       <= 1'b0;
      bit_cnt_r    <= 3'd0;
      shift_r      <= 7'd0;
      tx_r         <= 7'd0;
      ack_phase_r  <= 1'b0;
      rw_r         <= 1'b0;
      first_byte_r <= 1'b0;
      load_pend_r  <= 1'b0;
      ptr_r        <= 3'd0;
      temp_q_r     <= 16'h0000;
      cfg_r        <= 8'h00;
      tos_r        <= TOS_RST;
      thyst_r      <= THYST_RST;
    end else begin
      sda_oe_r <= oe_next_s;
      busy_r   <= busy_next_s;
      if (start_s || stop_s) begin
        bit_cnt_r   <= 3'd0;
        ack_phase_r <= 1'b0;
        load_pend_r <= 1'b0;
      end else begin
        case (state_r)
          ST_ADDR: if (rise_s) begin
            shift_r   <= rx_byte_s[6:0];
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_done_s) begin
              rw_r <= sda_s;
              if (addr_hit_s && sda_s) temp_q_r <= temp_i;
            end
          end
          ST_ADDR_ACK, ST_WR_ACK: if (fall_s) begin
            ack_phase_r <= ~ack_phase_r;
            if (state_r == ST_ADDR_ACK && ack_phase_r) begin
              first_byte_r <= ~rw_r;
              tx_r         <= rd_data_s[6:0];
            end
          end
          ST_WR_BYTE: if (rise_s) begin
            shift_r   <= rx_byte_s[6:0];
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_done_s && first_byte_r) begin
              ptr_r        <= rx_byte_s[2:0];
              first_byte_r <= 1'b0;
            end else if (bit_done_s) begin
              case (ptr_r)
                REG_CONFIG: cfg_r   <= rx_byte_s;
                REG_TOS:    tos_r   <= rx_byte_s;
                REG_THYST:  thyst_r <= rx_byte_s;
                default:    ;
              endcase
              ptr_r <= ptr_r + 3'd1;
            end
          end
          ST_RD_BYTE: begin
            if (rise_s) bit_cnt_r <= bit_cnt_r + 3'd1;
            if (fall_s && load_pend_r) begin
              tx_r        <= rd_data_s[6:0];
              load_pend_r <= 1'b0;
            end else if (fall_s) begin
              tx_r <= {tx_r[5:0], 1'b0};
            end
          end
          ST_RD_ACK: if (fall_s && !ack_phase_r) begin
            ack_phase_r <= 1'b1;
          end else if (rise_s && ack_phase_r) begin
            ack_phase_r <= 1'b0;
            ptr_r       <= ptr_r + 3'd1;
            load_pend_r <= ~sda_s;
          end
          default: ;
        endcase
      end
    end
  end

  // Alert with hysteresis; holds between THYST and TOS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alert_r <= 1'b0;
    else if (!cfg_r[CFG_ALERT_EN_BIT]) alert_r <= 1'b0;
    else if ($signed(temp_i[15:8]) < $signed(thyst_r)) alert_r <= 1'b0;
    else if ($signed(temp_i[15:8]) >= $signed(tos_r)) alert_r <= 1'b1;
    else alert_r <= alert_r;
  end

  assign sda_oe  = sda_oe_r;
  assign busy_o  = busy_r;
  assign alert_o = alert_r;
  assign cfg_o   = cfg_r;

endmodule

// File: tb/tb_i2c_temp_responder.sv
// Scoreboard bench: a bit-banged I2C master drives the responder; expected items
// are queued at issue time and a monitor process compares them with observed ones.
module tb_i2c_temp_responder;

  localparam int QTR = 8;

  typedef struct {
    string       name;
    logic [15:0] val;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scl_m, sda_m;
  logic        sda_oe, alert_o, busy_o;
  logic [15:0] temp;
  logic [7:0]  cfg_o;
  logic        sda_bus;

  item_t exp_q[$];
  item_t act_q[$];
  item_t e_it, a_it;
  int    checks = 0;
  int    errors = 0;
  logic  watch_oe = 1'b0;
  logic  oe_seen = 1'b0;
  logic  oe_prev = 1'b0;
  int    hi_change_cnt = 0;

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_temp_responder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .scl_i   (scl_m),
    .sda_i   (sda_bus),
    .sda_oe  (sda_oe),
    .temp_i  (temp),
    .alert_o (alert_o),
    .busy_o  (busy_o),
    .cfg_o   (cfg_o)
  );

  // Scoreboard monitor: pops matched expected/observed pairs.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e_it = exp_q.pop_front();
      a_it = act_q.pop_front();
      checks++;
      if (e_it.name != a_it.name || e_it.val !== a_it.val) begin
        errors++;
        $display("FAIL %s: got %h (%s) expected %h", e_it.name, a_it.val, a_it.name, e_it.val);
      end
    end
  end

  // Bus watcher: SDA drive must never change while SCL is high.
  always @(negedge clk) begin
    if (rst_n && (sda_oe != oe_prev) && scl_m) hi_change_cnt++;
    if (watch_oe && sda_oe) oe_seen = 1'b1;
    oe_prev = sda_oe;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

  task automatic expect_val(input string n, input logic [15:0] v);
    exp_q.push_back('{n, v});
  endtask

  task automatic observe(input string n, input logic [15:0] v);
    act_q.push_back('{n, v});
  endtask

  task automatic chk(input string n, input logic [15:0] e, input logic [15:0] v);
    expect_val(n, e);
    observe(n, v);
  endtask

  task automatic q();
    repeat (QTR) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; q(); scl_m = 1'b1; q(); sda_m = 1'b0; q(); scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    q(); sda_m = 1'b0; q(); scl_m = 1'b1; q(); sda_m = 1'b1; q();
  endtask

  task automatic write_bit(input logic b, input logic g);
    q(); sda_m = b; q(); scl_m = 1'b1;
    if (g) begin
      repeat (3) @(negedge clk);
      sda_m = 1'b0;
      @(negedge clk);
      sda_m = b;
      repeat (4) @(negedge clk);
    end else begin
      q();
    end
    q(); scl_m = 1'b0;
  endtask

  task automatic read_bit(output logic r);
    q(); sda_m = 1'b1; q(); scl_m = 1'b1; q(); r = sda_bus; q(); scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, input logic g, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i], g && (i == 7));
    read_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic bt;
    for (int i = 7; i >= 0; i--) begin
      read_bit(bt);
      d[i] = bt;
    end
    write_bit(nack, 1'b0);
  endtask

  task automatic wr(input logic [7:0] b, input logic exp_ack, input string n);
    logic a;
    expect_val(n, {15'd0, exp_ack});
    write_byte(b, 1'b0, a);
    observe(n, {15'd0, a});
  endtask

  task automatic rd(input logic nack, input logic [7:0] exp_d, input string n);
    logic [7:0] d;
    expect_val(n, {8'd0, exp_d});
    read_byte(nack, d);
    observe(n, {8'd0, d});
  endtask

  task automatic read_tos(input logic [7:0] exp_d, input string n);
    bus_start(); wr(8'h90, 1'b0, "addr_w"); wr(8'h03, 1'b0, "ptr_tos");
    bus_start(); wr(8'h91, 1'b0, "addr_r"); rd(1'b1, exp_d, n); bus_stop();
  endtask

  initial begin
    logic [7:0] sweep_t [4];
    logic       sweep_a [4];
    logic       bt;
    logic       ga;
    sweep_t = '{8'h4A, 8'h50, 8'h4C, 8'h4A};
    sweep_a = '{1'b0, 1'b1, 1'b1, 1'b0};
    scl_m = 1'b1; sda_m = 1'b1; temp = 16'h1900; rst_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_oe", 16'd0, {15'd0, sda_oe});
    chk("rst_alert", 16'd0, {15'd0, alert_o});
    chk("rst_busy", 16'd0, {15'd0, busy_o});
    chk("rst_cfg", 16'h0000, {8'd0, cfg_o});
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Write TOS = 0x64, then read TOS and THYST back through a repeated START.
    bus_start(); wr(8'h90, 1'b0, "addr_w");
    chk("busy_on", 16'd1, {15'd0, busy_o});
    wr(8'h03, 1'b0, "ptr_tos"); wr(8'h64, 1'b0, "wr_tos"); bus_stop();
    repeat (4) @(negedge clk);
    chk("busy_off", 16'd0, {15'd0, busy_o});
    bus_start(); wr(8'h90, 1'b0, "addr_w"); wr(8'h03, 1'b0, "ptr_tos");
    bus_start(); wr(8'h91, 1'b0, "addr_r");
    rd(1'b0, 8'h64, "rd_tos"); rd(1'b1, 8'h4B, "rd_thyst"); bus_stop();
    chk("alert_cfg0", 16'd0, {15'd0, alert_o});

    // Temperature snapshot must survive a change between bytes.
    temp = 16'h1980;
    bus_start(); wr(8'h90, 1'b0, "addr_w"); wr(8'h00, 1'b0, "ptr_hi");
    bus_start(); wr(8'h91, 1'b0, "addr_r");
    rd(1'b0, 8'h19, "rd_temp_hi");
    temp = 16'h2000;
    rd(1'b1, 8'h80, "rd_temp_lo"); bus_stop();

    // Foreign address: no drive, not busy, no register update.
    oe_seen = 1'b0; watch_oe = 1'b1;
    bus_start(); wr(8'h92, 1'b1, "nack_addr");
    chk("busy_foreign", 16'd0, {15'd0, busy_o});
    wr(8'h03, 1'b1, "nack_ptr"); wr(8'h11, 1'b1, "nack_data"); bus_stop();
    watch_oe = 1'b0;
    chk("oe_foreign", 16'd0, {15'd0, oe_seen});
    read_tos(8'h64, "tos_kept");

    // Alert hysteresis with CONFIG = 0x01, TOS = 0x50.
    bus_start(); wr(8'h90, 1'b0, "addr_w"); wr(8'h02, 1'b0, "ptr_cfg");
    wr(8'h01, 1'b0, "wr_cfg"); wr(8'h50, 1'b0, "wr_tos"); bus_stop();
    chk("cfg_en", 16'h0001, {8'd0, cfg_o});
    for (int i = 0; i < 4; i++) begin
      temp = {sweep_t[i], 8'h00};
      repeat (4) @(negedge clk);
      chk($sformatf("alert_%0d", i), {15'd0, sweep_a[i]}, {15'd0, alert_o});
    end
    temp = 16'h5500;
    repeat (4) @(negedge clk);
    chk("alert_set", 16'd1, {15'd0, alert_o});
    bus_start(); wr(8'h90, 1'b0, "addr_w"); wr(8'h02, 1'b0, "ptr_cfg");
    wr(8'h00, 1'b0, "wr_cfg"); wr(8'h64, 1'b0, "wr_tos"); bus_stop();
    chk("alert_disable", 16'd0, {15'd0, alert_o});

`ifdef I2C_RESP_GLITCH_FILTER_EN
    // One-cycle SDA low pulse during SCL high must not look like START/STOP.
    bus_start(); wr(8'h90, 1'b0, "addr_w"); wr(8'h04, 1'b0, "ptr_thyst");
    expect_val("glitch_ack", 16'd0);
    write_byte(8'hC8, 1'b1, ga);
    observe("glitch_ack", {15'd0, ga});
    bus_stop();
    bus_start(); wr(8'h90, 1'b0, "addr_w"); wr(8'h04, 1'b0, "ptr_thyst");
    bus_start(); wr(8'h91, 1'b0, "addr_r"); rd(1'b1, 8'hC8, "rd_glitch"); bus_stop();
`endif

    // Async reset in the middle of a read byte (TOS = 0x64, bit7 = 0 driven low).
    bus_start(); wr(8'h90, 1'b0, "addr_w"); wr(8'h03, 1'b0, "ptr_tos");
    bus_start(); wr(8'h91, 1'b0, "addr_r");
    q(); sda_m = 1'b1; q(); scl_m = 1'b1; q();
    bt = sda_bus;
    chk("oe_before_rst", 16'd1, {15'd0, sda_oe});
    chk("bit7_before_rst", 16'd0, {15'd0, bt});
    rst_n = 1'b0;
    #1;
    chk("oe_at_rst", 16'd0, {15'd0, sda_oe});
    scl_m = 1'b1; sda_m = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    read_tos(8'h50, "tos_after_rst");
    chk("cfg_after_rst", 16'h0000, {8'd0, cfg_o});
    chk("oe_stable_scl_hi", 16'd0, hi_change_cnt[15:0]);

    repeat (5) @(negedge clk);
    if (exp_q.size() != 0 || act_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d expected / %0d observed left, expected 0/0",
               exp_q.size(), act_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
